// File: rtl/mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_stage                                                         |
// | M-stage load/store handshake with a variable-latency data memory; stalls |
// | the pipeline and bubbles MEM/WB control while the access is outstanding. |
// | Optional: define DMEM_TIMEOUT_EN to abort hung accesses and flag errM.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_access_stage #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 24,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memReadM,
    input  logic              memWriteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic              regWriteM,
    input  logic              memToRegM,
    input  logic              PCSrcM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] RD,
    output logic              regWriteOut,
    output logic              memToRegOut,
    output logic              PCSrcOut,
    output logic              stallM,
    output logic              errM
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       w_op;
    logic       w_ack_busy;
    logic       w_timeout;

    assign w_op       = memReadM | memWriteM;
    assign w_ack_busy = (r_state == c_BUSY) && dmem_ack;

`ifdef DMEM_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    // Timeout fires in the BUSY cycle whose increment would reach TIMEOUT_CYCLES.
    assign w_timeout = (r_state == c_BUSY) && !dmem_ack && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state != c_BUSY) begin
                r_cnt <= '0;
            end else if (!dmem_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign errM = r_err;
`else
    localparam logic [31:0] c_TIMEOUT = TIMEOUT_CYCLES;
    logic w_unused_timeout;

    assign w_unused_timeout = ^c_TIMEOUT;
    assign w_timeout        = 1'b0;
    assign errM             = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_op) w_next_state = c_BUSY;
            c_BUSY:  if (dmem_ack || w_timeout) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            RD         <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_we    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_IDLE) && w_op) begin
                dmem_addr  <= ALUOutM;
                dmem_wdata <= WriteDataM;
                dmem_we    <= memWriteM;
            end
            if (w_ack_busy && !dmem_we) begin
                RD <= dmem_rdata;
            end else if (w_timeout && !dmem_we) begin
                RD <= '0;
            end
        end
    end

    assign dmem_req    = (r_state == c_BUSY);
    assign stallM      = (r_state == c_BUSY) || ((r_state == c_IDLE) && w_op);
    assign regWriteOut = regWriteM & ~stallM;
    assign memToRegOut = memToRegM & ~stallM;
    assign PCSrcOut    = PCSrcM & ~stallM;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_stage                                                      |
// | Directed and randomized transactions against a transaction-level model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_access_stage;

    localparam int AW = 16;
    localparam int DW = 24;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          memReadM, memWriteM;
    logic [AW-1:0] ALUOutM;
    logic [DW-1:0] WriteDataM;
    logic          regWriteM, memToRegM, PCSrcM;
    logic          dmem_req, dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;
    logic [DW-1:0] RD;
    logic          regWriteOut, memToRegOut, PCSrcOut;
    logic          stallM, errM;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] model_rd;
    logic          exp_err;

    mem_access_stage #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .memReadM(memReadM), .memWriteM(memWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .regWriteM(regWriteM), .memToRegM(memToRegM), .PCSrcM(PCSrcM),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .RD(RD),
        .regWriteOut(regWriteOut), .memToRegOut(memToRegOut), .PCSrcOut(PCSrcOut),
        .stallM(stallM), .errM(errM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One M-stage instruction; lat = BUSY cycle carrying the ack, 0 = memory never answers.
    task automatic run_instr(input logic rd, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [2:0] ctl,
                             input int lat, input logic [DW-1:0] rdata);
        int   stalls;
        int   nb;
        logic op;
        stalls = 0;
        op     = rd | wr;
        nb     = (lat == 0) ? TO : lat;
        memReadM = rd; memWriteM = wr; ALUOutM = a; WriteDataM = wd;
        {regWriteM, memToRegM, PCSrcM} = ctl;
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = DW'($urandom);
        @(negedge clk);
        chk("idle_stall", 32'(stallM), 32'(op));
        chk("idle_req", 32'(dmem_req), 32'd0);
        chk("idle_ctl", 32'({regWriteOut, memToRegOut, PCSrcOut}), op ? 32'd0 : 32'(ctl));
        if (stallM) stalls++;
        tick();
        if (!op) begin
            dmem_ack = 1'b0;
            return;
        end
        for (int k = 1; k <= nb; k++) begin
            dmem_ack   = (lat != 0) && (k == lat);
            dmem_rdata = (k == lat) ? rdata : DW'($urandom);
            @(negedge clk);
            chk("busy_req", 32'(dmem_req), 32'd1);
            chk("busy_stall", 32'(stallM), 32'd1);
            chk("busy_we", 32'(dmem_we), 32'(wr));
            chk("busy_addr", 32'(dmem_addr), 32'(a));
            chk("busy_wdata", 32'(dmem_wdata), 32'(wd));
            chk("busy_ctl", 32'({regWriteOut, memToRegOut, PCSrcOut}), 32'd0);
            if (stallM) stalls++;
            tick();
        end
        if (lat == 0) begin
            exp_err = 1'b1;
            if (!wr) model_rd = '0;
        end else if (!wr) begin
            model_rd = rdata;
        end
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = DW'($urandom);
        @(negedge clk);
        chk("done_stall", 32'(stallM), 32'd0);
        chk("done_req", 32'(dmem_req), 32'd0);
        chk("done_ctl", 32'({regWriteOut, memToRegOut, PCSrcOut}), 32'(ctl));
        chk("done_rd", 32'(RD), 32'(model_rd));
        chk("done_err", 32'(errM), 32'(exp_err));
        chk("stall_count", 32'(stalls), 32'(nb + 1));
        tick();
        dmem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; memReadM = 0; memWriteM = 0; ALUOutM = '0; WriteDataM = '0;
        regWriteM = 0; memToRegM = 0; PCSrcM = 0; dmem_ack = 0; dmem_rdata = '0;
        model_rd = '0; exp_err = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rd", 32'(RD), 32'd0);
        chk("rst_stall", 32'(stallM), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_err", 32'(errM), 32'd0);
        chk("rst_addr", 32'(dmem_addr), 32'd0);
        chk("rst_wdata", 32'(dmem_wdata), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        tick();

        run_instr(1'b1, 1'b0, 16'h0040, 24'h0, 3'b100, 3, 24'hA5B6C7);
        run_instr(1'b0, 1'b1, 16'h0010, 24'h123456, 3'b000, 1, 24'h0);
        run_instr(1'b1, 1'b0, 16'h0001, 24'h0, 3'b110, 1, 24'h111111);
        run_instr(1'b1, 1'b0, 16'h0002, 24'h0, 3'b110, 1, 24'h222222);
        run_instr(1'b0, 1'b0, 16'h0055, 24'h0, 3'b111, 1, 24'h0);
        run_instr(1'b1, 1'b1, 16'h0077, 24'hABCDEF, 3'b001, 2, 24'h333333);
        run_instr(1'b1, 1'b0, 16'h0099, 24'h0, 3'b100, TO, 24'h444444);
`ifdef DMEM_TIMEOUT_EN
        run_instr(1'b1, 1'b0, 16'h0123, 24'h0, 3'b100, 0, 24'h0);
        run_instr(1'b1, 1'b0, 16'h0124, 24'h0, 3'b100, 2, 24'h5A5A5A);
`endif

        for (int i = 0; i < 40; i++) begin
            run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom),
                      DW'($urandom), 3'($urandom), int'($urandom_range(1, TO)), DW'($urandom));
        end

        // Reset while BUSY, then a late ack that must be ignored.
        memReadM = 1'b1; memWriteM = 1'b0; ALUOutM = 16'h0BAD;
        tick();
        @(negedge clk);
        chk("mid_busy_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; memReadM = 1'b0;
        model_rd = '0; exp_err = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", 32'(dmem_req), 32'd0);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 24'hDEAD01;
        @(negedge clk);
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        tick();
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_rd", 32'(RD), 32'(model_rd));
        chk("late_ack_stall", 32'(stallM), 32'd0);
        chk("late_ack_err", 32'(errM), 32'(exp_err));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
